// File: rtl/cordic_sweep_bist.sv
// Angle-sweep self-test harness for a pipelined rotation-mode CORDIC.
// Issues a stored angle table, checks cos/sin against golden values within TOL.
module cordic_sweep_bist #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 360,
    parameter int AW        = 9,
    parameter int TOL       = 2,
    parameter int ISSUE_GAP = 0,
    parameter int TIMEOUT   = 64,
    parameter int CW        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tbl_we,
    input  logic [AW-1:0]    tbl_addr,
    input  logic [WIDTH-1:0] tbl_angle,
    input  logic [WIDTH-1:0] tbl_cos,
    input  logic [WIDTH-1:0] tbl_sin,
    input  logic             start,
    input  logic             loop,
    input  logic             stop,
    output logic [WIDTH-1:0] dut_x,
    output logic [WIDTH-1:0] dut_y,
    output logic [WIDTH-1:0] dut_z,
    output logic             dut_mode,
    output logic             dut_valid_in,
    input  logic             dut_valid_out,
    input  logic [WIDTH-1:0] dut_cos,
    input  logic [WIDTH-1:0] dut_sin,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    err_count,
    output logic [AW-1:0]    first_err_idx,
    output logic [CW-1:0]    latency,
    output logic             timeout,
    output logic             overflow
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    // CORDIC gain K = 0.60725293..., held as K*2^32 and rescaled to 2^(WIDTH-2)
    localparam logic [63:0] KQ32 = 64'd2608131496;
    localparam logic [WIDTH-1:0] XK = WIDTH'((KQ32 << (WIDTH - 2)) >> 32);

    logic [WIDTH-1:0] mem_ang [DEPTH];
    logic [WIDTH-1:0] mem_cos [DEPTH];
    logic [WIDTH-1:0] mem_sin [DEPTH];

    state_t         state, state_n;
    logic [AW-1:0]  issue_idx;
    logic [AW:0]    issued_cnt;
    logic [AW:0]    rx_idx;
    logic [GW-1:0]  gap_cnt;
    logic [TW-1:0]  idle_cnt;
    logic           loop_q, stop_q;
    logic           err_seen;
    logic           lat_on, lat_done;

    logic           active, issue_fire, start_ok;
    logic           rx_ok, rx_cmp, rx_ovf, mism;
    logic           idle_tick, to_fire, sweep_end, stop_eff;
    logic [WIDTH:0] dc, ds, absc, abss;

    always_ff @(posedge clk) begin
        if (tbl_we && !busy && (32'(tbl_addr) < DEPTH)) begin
            mem_ang[tbl_addr] <= tbl_angle;
            mem_cos[tbl_addr] <= tbl_cos;
            mem_sin[tbl_addr] <= tbl_sin;
        end
    end

    assign active     = (state == S_ISSUE) || (state == S_DRAIN);
    assign busy       = active;
    assign done       = (state == S_DONE);
    assign pass       = done && (err_count == '0) && !timeout && !overflow;
    assign issue_fire = (state == S_ISSUE) && (gap_cnt == '0);
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));

    assign dut_x        = XK;
    assign dut_y        = '0;
    assign dut_mode     = 1'b1;
    assign dut_valid_in = issue_fire;
    assign dut_z        = issue_fire ? mem_ang[issue_idx] : '0;

    // Results are only meaningful once a run has been started.
    assign rx_ok  = dut_valid_out && (active || done);
    assign rx_cmp = rx_ok && (rx_idx < issued_cnt);
    assign rx_ovf = rx_ok && !(rx_idx < issued_cnt);

    assign dc   = {dut_cos[WIDTH-1], dut_cos}
                - {mem_cos[rx_idx[AW-1:0]][WIDTH-1], mem_cos[rx_idx[AW-1:0]]};
    assign ds   = {dut_sin[WIDTH-1], dut_sin}
                - {mem_sin[rx_idx[AW-1:0]][WIDTH-1], mem_sin[rx_idx[AW-1:0]]};
    assign absc = dc[WIDTH] ? -dc : dc;
    assign abss = ds[WIDTH] ? -ds : ds;
    assign mism = (absc > (WIDTH+1)'(TOL)) || (abss > (WIDTH+1)'(TOL));

    assign idle_tick = active && (issued_cnt != rx_idx) && !dut_valid_out;
    assign to_fire   = idle_tick && (idle_cnt == TW'(TIMEOUT - 1));
    assign sweep_end = (state == S_DRAIN) && (rx_idx == (AW+1)'(DEPTH));
    assign stop_eff  = stop_q || stop;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (to_fire)
                    state_n = S_DONE;
                else if (issue_fire && issue_idx == AW'(DEPTH - 1))
                    state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (to_fire)
                    state_n = S_DONE;
                else if (sweep_end)
                    state_n = (loop_q && !stop_eff) ? S_ISSUE : S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            issue_idx     <= '0;
            issued_cnt    <= '0;
            rx_idx        <= '0;
            gap_cnt       <= '0;
            idle_cnt      <= '0;
            loop_q        <= 1'b0;
            stop_q        <= 1'b0;
            err_count     <= '0;
            err_seen      <= 1'b0;
            first_err_idx <= '0;
            latency       <= '0;
            lat_on        <= 1'b0;
            lat_done      <= 1'b0;
            timeout       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state <= state_n;
            if (start_ok) begin
                issue_idx     <= '0;
                issued_cnt    <= '0;
                rx_idx        <= '0;
                gap_cnt       <= '0;
                idle_cnt      <= '0;
                loop_q        <= loop;
                stop_q        <= 1'b0;
                err_count     <= '0;
                err_seen      <= 1'b0;
                first_err_idx <= '0;
                latency       <= '0;
                lat_on        <= 1'b0;
                lat_done      <= 1'b0;
                timeout       <= 1'b0;
                overflow      <= 1'b0;
            end else begin
                if (active && stop) stop_q <= 1'b1;

                if (issue_fire) begin
                    issued_cnt <= issued_cnt + 1'b1;
                    issue_idx  <= (issue_idx == AW'(DEPTH - 1)) ? '0 : issue_idx + 1'b1;
                    gap_cnt    <= GW'(ISSUE_GAP);
                end else if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end

                if (rx_cmp) begin
                    rx_idx <= rx_idx + 1'b1;
                    if (mism) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (!err_seen) begin
                            err_seen      <= 1'b1;
                            first_err_idx <= rx_idx[AW-1:0];
                        end
                    end
                end
                if (rx_ovf) overflow <= 1'b1;

                idle_cnt <= idle_tick ? idle_cnt + 1'b1 : '0;
                if (to_fire) timeout <= 1'b1;

                // The issue cycle itself counts, so a 12-stage pipe reads 12.
                if (issue_fire && !lat_on) begin
                    lat_on  <= 1'b1;
                    latency <= CW'(1);
                end else if (active && lat_on && !lat_done) begin
                    if (dut_valid_out)
                        lat_done <= 1'b1;
                    else if (latency != '1)
                        latency <= latency + 1'b1;
                end

                if (sweep_end && state_n == S_ISSUE) begin
                    issue_idx  <= '0;
                    issued_cnt <= '0;
                    rx_idx     <= '0;
                    gap_cnt    <= '0;
                    idle_cnt   <= '0;
                end
            end
        end
    end

endmodule
